// File: rtl/rr_arb4_32.sv
// rr_arb4_32 -- four-requester round-robin arbiter with bounded bursts.
//
// Shares one 4:1 WIDTH-bit selection path among four valid/ready producers.
// The selected word is captured into a one-entry output register. A winner
// may keep ownership for up to BURST back-to-back words before the grant
// rotates.
//
// Handshake rules (all ports): a word moves on a rising edge when its valid
// and ready are both 1 at that edge. Valid may drop without a handshake.
// The arbiter never captures a word unless it raised the matching ready.
// req_ready is combinational, at most one bit set, and all-zero while the
// output register is full and not draining, or while rst is high.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   req_valid    per-requester valid (bit i = requester i)
//   req_data0..3 requester payloads
//   req_ready    per-requester accept (one-hot or zero)
//   out_valid    output register holds a word
//   out_data     registered selected word
//   out_sel      index of the requester that produced out_data
//   out_ready    sink accepts out_data
//   busy         grant FSM is in OWN (doubles as the FSM state view)

module rr_arb4_32 #(
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
  output logic [3:0]       req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam logic [3:0] BURST_C = 4'(BURST);

  state_t     state, state_d;
  logic [1:0] last, last_d;
  logic [3:0] cnt, cnt_d;

  logic       can_load;
  logic       found;
  logic [1:0] win;
  logic [1:0] cand;
  logic       load;
  logic [1:0] load_sel;
  logic [WIDTH-1:0] sel_data;

  assign can_load = !out_valid || out_ready;
  assign busy     = (state == OWN);

  // Round-robin scan starting just after the last winner, wrapping at 3.
  always_comb begin
    found = 1'b0;
    win   = last;
    cand  = last;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Grant FSM: next state, burst bookkeeping and the ready decode.
  always_comb begin
    state_d   = state;
    last_d    = last;
    cnt_d     = cnt;
    load      = 1'b0;
    load_sel  = last;
    req_ready = 4'b0000;
    if (!rst && can_load) begin
      unique case (state)
        IDLE: begin
          if (found) begin
            load     = 1'b1;
            load_sel = win;
            last_d   = win;
            cnt_d    = 4'd1;
            state_d  = (BURST > 1) ? OWN : IDLE;
          end
        end
        OWN: begin
          if (req_valid[last]) begin
            load     = 1'b1;
            load_sel = last;
            cnt_d    = cnt + 4'd1;
            if (cnt + 4'd1 == BURST_C) state_d = IDLE;
          end else if (found) begin
            // Owner went quiet: hand over in the same cycle, no bubble.
            load     = 1'b1;
            load_sel = win;
            last_d   = win;
            cnt_d    = 4'd1;
            state_d  = (BURST > 1) ? OWN : IDLE;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (load) req_ready[load_sel] = 1'b1;
    end
  end

  // Shared 4:1 selection path.
  always_comb begin
    unique case (load_sel)
      2'd0:    sel_data = req_data0;
      2'd1:    sel_data = req_data1;
      2'd2:    sel_data = req_data2;
      default: sel_data = req_data3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 2'd3;
      cnt       <= 4'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
    end else begin
      state <= state_d;
      last  <= last_d;
      cnt   <= cnt_d;
      if (load) begin
        // A load may coincide with an unload; the new word simply replaces it.
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= load_sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb4_32.sv
// Bench for rr_arb4_32: one instance with BURST=1 (a_*) and one with
// BURST=4 (b_*). Directed vectors push expected {sel, data} words into a
// queue per instance; a monitor per instance pops and compares on every
// sink handshake.

module tb_rr_arb4_32;

  localparam int W = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A (BURST=1)
  logic        a_rst;
  logic [3:0]  a_req_valid;
  logic [31:0] a_d0, a_d1, a_d2, a_d3;
  logic [3:0]  a_req_ready;
  logic        a_out_valid;
  logic [31:0] a_out_data;
  logic [1:0]  a_out_sel;
  logic        a_out_ready;
  logic        a_busy;

  // Instance B (BURST=4)
  logic        b_rst;
  logic [3:0]  b_req_valid;
  logic [31:0] b_d0, b_d1, b_d2, b_d3;
  logic [3:0]  b_req_ready;
  logic        b_out_valid;
  logic [31:0] b_out_data;
  logic [1:0]  b_out_sel;
  logic        b_out_ready;
  logic        b_busy;

  rr_arb4_32 #(.WIDTH(32), .BURST(1)) u_a (
    .clk(clk), .rst(a_rst), .req_valid(a_req_valid),
    .req_data0(a_d0), .req_data1(a_d1), .req_data2(a_d2), .req_data3(a_d3),
    .req_ready(a_req_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_sel(a_out_sel), .out_ready(a_out_ready), .busy(a_busy)
  );

  rr_arb4_32 #(.WIDTH(32), .BURST(4)) u_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid),
    .req_data0(b_d0), .req_data1(b_d1), .req_data2(b_d2), .req_data3(b_d3),
    .req_ready(b_req_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_sel(b_out_sel), .out_ready(b_out_ready), .busy(b_busy)
  );

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] word(input logic [1:0] sel, input logic [31:0] d);
    return {sel, d};
  endfunction

  // Monitors: one pop per sink handshake, ignored while reset discards.
  always @(negedge clk) begin
    if (!a_rst && a_out_valid && a_out_ready) begin
      if (exp_a_q.size() == 0) check("a_unexpected_word", {a_out_sel, a_out_data}, '1);
      else check("a_word", {a_out_sel, a_out_data}, exp_a_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!b_rst && b_out_valid && b_out_ready) begin
      if (exp_b_q.size() == 0) check("b_unexpected_word", {b_out_sel, b_out_data}, '1);
      else check("b_word", {b_out_sel, b_out_data}, exp_b_q.pop_front());
    end
  end

  initial begin
    logic [1:0] sel;
    a_rst = 1'b1; b_rst = 1'b1;
    a_req_valid = 4'b0; b_req_valid = 4'b0;
    a_d0 = 32'hA0; a_d1 = 32'hA1; a_d2 = 32'hA2; a_d3 = 32'hA3;
    b_d0 = 32'hA0; b_d1 = 32'hA1; b_d2 = 32'hA2; b_d3 = 32'hA3;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    step(); step();

    // Reset values
    @(negedge clk);
    check("a_rst_out_valid", W'(a_out_valid), W'(0));
    check("a_rst_out_data",  W'(a_out_data),  W'(0));
    check("a_rst_out_sel",   W'(a_out_sel),   W'(0));
    check("a_rst_busy",      W'(a_busy),      W'(0));
    check("a_rst_req_ready", W'(a_req_ready), W'(0));
    check("b_rst_out_valid", W'(b_out_valid), W'(0));
    check("b_rst_busy",      W'(b_busy),      W'(0));
    step();
    a_rst = 1'b0; b_rst = 1'b0;

    // A: BURST=1, all four valid -> 0,1,2,3,0,1,2,3
    a_req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      sel = 2'(k % 4);
      exp_a_q.push_back(word(sel, 32'hA0 + 32'(sel)));
      @(negedge clk);
      check("a_rr_req_ready", W'(a_req_ready), W'(4'b0001 << sel));
      check("a_rr_busy", W'(a_busy), W'(0));
      step();
    end
    a_req_valid = 4'b0000;
    step();
    @(negedge clk);
    check("a_idle_out_valid", W'(a_out_valid), W'(0));
    step();

    // B: BURST=4, requesters 0 and 1 -> 4x0, 4x1, 4x0
    b_req_valid = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      sel = ((c / 4) % 2 == 1) ? 2'd1 : 2'd0;
      exp_b_q.push_back(word(sel, 32'hA0 + 32'(sel)));
      @(negedge clk);
      check("b_burst_req_ready", W'(b_req_ready), W'(4'b0001 << sel));
      check("b_burst_busy", W'(b_busy), W'((c % 4) != 0));
      step();
    end
    b_req_valid = 4'b0000;
    @(negedge clk);
    check("b_burst_end_busy", W'(b_busy), W'(0));
    step();
    @(negedge clk);
    check("b_drain_out_valid", W'(b_out_valid), W'(0));
    step();

    // B: requester 2 for two words, then hand over to 3 without a bubble
    b_req_valid = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      exp_b_q.push_back(word(2'd2, 32'hA2));
      @(negedge clk);
      check("b_r2_req_ready", W'(b_req_ready), W'(4'b0100));
      step();
    end
    b_req_valid = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      exp_b_q.push_back(word(2'd3, 32'hA3));
      @(negedge clk);
      check("b_r3_req_ready", W'(b_req_ready), W'(4'b1000));
      step();
    end
    b_req_valid = 4'b0000;
    step();
    @(negedge clk);
    check("b_handover_out_valid", W'(b_out_valid), W'(0));
    check("b_handover_busy", W'(b_busy), W'(0));
    step();

    // B: back-pressure for three cycles, then load in the release cycle
    b_req_valid = 4'b0001;
    exp_b_q.push_back(word(2'd0, 32'hA0));
    @(negedge clk);
    check("b_bp_first_ready", W'(b_req_ready), W'(4'b0001));
    step();
    b_out_ready = 1'b0;
    b_d0 = 32'hB0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("b_bp_req_ready", W'(b_req_ready), W'(0));
      check("b_bp_hold_word", {b_out_valid, b_out_sel, b_out_data[30:0]}, {1'b1, 2'd0, 31'hA0});
      check("b_bp_hold_data", W'(b_out_data), W'(32'hA0));
      step();
    end
    b_out_ready = 1'b1;
    exp_b_q.push_back(word(2'd0, 32'hB0));
    @(negedge clk);
    check("b_bp_release_ready", W'(b_req_ready), W'(4'b0001));
    step();
    b_req_valid = 4'b0000;
    b_d0 = 32'hA0;
    step();
    @(negedge clk);
    check("b_bp_drain_out_valid", W'(b_out_valid), W'(0));
    step();

    // B: reset mid-burst, then first grant goes to lowest valid index
    b_req_valid = 4'b0011;
    exp_b_q.push_back(word(2'd1, 32'hA1));
    @(negedge clk);
    check("b_pre_rst_ready0", W'(b_req_ready), W'(4'b0010));
    step();
    @(negedge clk);
    check("b_pre_rst_ready1", W'(b_req_ready), W'(4'b0010));
    check("b_pre_rst_busy", W'(b_busy), W'(1));
    step();
    b_rst = 1'b1;
    @(negedge clk);
    check("b_rst_cycle_ready", W'(b_req_ready), W'(0));
    step();
    b_rst = 1'b0;
    b_req_valid = 4'b0110;
    exp_b_q.push_back(word(2'd1, 32'hA1));
    @(negedge clk);
    check("b_post_rst_out_valid", W'(b_out_valid), W'(0));
    check("b_post_rst_busy", W'(b_busy), W'(0));
    check("b_post_rst_ready", W'(b_req_ready), W'(4'b0010));
    step();
    b_req_valid = 4'b0000;

    // Drain with a bounded wait
    for (int c = 0; c < 20; c++) begin
      if (exp_a_q.size() == 0 && exp_b_q.size() == 0) break;
      step();
    end
    step();
    check("a_queue_empty", W'(exp_a_q.size()), W'(0));
    check("b_queue_empty", W'(exp_b_q.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
